// File: rtl/tetris_move_scheduler_if.sv
// Command channel between the move scheduler and the board executor.
//   cmd_valid : a command is offered (driven by the scheduler)
//   cmd       : 3-bit command code (0 NONE, 1 LEFT, 2 RIGHT, 3 ROTATE,
//               4 DOWN, 5 LOCK, 6 SPAWN)
//   cmd_ready : the board takes the command when cmd_valid && cmd_ready
interface tetris_move_scheduler_if;
    logic       cmd_valid;
    logic [2:0] cmd;
    logic       cmd_ready;

    modport master (output cmd_valid, output cmd, input cmd_ready);
    modport slave  (input cmd_valid, input cmd, output cmd_ready);
endinterface

// File: rtl/tetris_move_scheduler.sv
// Falling-piece sequencing controller. It merges gravity ticks and player
// requests into a single serialized command stream. It also runs spawn,
// lock delay, line clear and game over.
//   clk, reset (async, active-low)
//   start, move, moveFast, soft_drop, left, right, rotate : request pulses/levels
//   blocked_down, spawn_blocked, clear_done               : board status
//   cmd_bus (master)                                      : command handshake
//   game_over, state_o                                    : status outputs
module tetris_move_scheduler #(
    parameter int LOCK_TICKS = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           move,
    input  logic                           moveFast,
    input  logic                           soft_drop,
    input  logic                           left,
    input  logic                           right,
    input  logic                           rotate,
    input  logic                           blocked_down,
    input  logic                           spawn_blocked,
    input  logic                           clear_done,
    tetris_move_scheduler_if.master        cmd_bus,
    output logic                           game_over,
    output logic [2:0]                     state_o
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SPAWN     = 3'd1,
        S_FALL      = 3'd2,
        S_LOCK_WAIT = 3'd3,
        S_LOCK      = 3'd4,
        S_CLEAR     = 3'd5,
        S_OVER      = 3'd6
    } state_t;

    localparam logic [2:0] CMD_NONE   = 3'd0;
    localparam logic [2:0] CMD_LEFT   = 3'd1;
    localparam logic [2:0] CMD_RIGHT  = 3'd2;
    localparam logic [2:0] CMD_ROTATE = 3'd3;
    localparam logic [2:0] CMD_DOWN   = 3'd4;
    localparam logic [2:0] CMD_LOCK   = 3'd5;
    localparam logic [2:0] CMD_SPAWN  = 3'd6;

    // Pending flag bit positions.
    localparam int F_LEFT = 0;
    localparam int F_RIGHT = 1;
    localparam int F_ROT = 2;
    localparam int F_GRAV = 3;

    state_t     state;
    logic [3:0] flags;
    logic [3:0] lock_cnt;
    logic       cmd_valid_q;
    logic [2:0] cmd_q;

    logic       grav_evt;
    logic       accept;
    logic       in_play;
    logic [3:0] flag_set;
    logic [3:0] flag_clr;
    logic [3:0] flags_nxt;

    assign cmd_bus.cmd_valid = cmd_valid_q;
    assign cmd_bus.cmd       = cmd_q;
    assign state_o           = 3'(state);

    always_comb begin
        grav_evt = move | (moveFast & soft_drop);
        accept   = cmd_valid_q & cmd_bus.cmd_ready;
        in_play  = (state == S_FALL) || (state == S_LOCK_WAIT);
        flag_set = in_play ? {grav_evt, rotate, right, left} : 4'b0000;
        flag_clr = 4'b0000;
        if (accept) begin
            flag_clr[F_LEFT]  = (cmd_q == CMD_LEFT);
            flag_clr[F_RIGHT] = (cmd_q == CMD_RIGHT);
            flag_clr[F_ROT]   = (cmd_q == CMD_ROTATE);
            flag_clr[F_GRAV]  = (cmd_q == CMD_DOWN);
        end
        // A pulse on the clearing edge re-arms its flag.
        flags_nxt = (flags & ~flag_clr) | flag_set;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            flags       <= 4'b0000;
            lock_cnt    <= 4'd0;
            cmd_valid_q <= 1'b0;
            cmd_q       <= CMD_NONE;
            game_over   <= 1'b0;
        end else begin
            flags <= flags_nxt;
            if (accept) begin
                cmd_valid_q <= 1'b0;
                cmd_q       <= CMD_NONE;
            end
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state       <= S_SPAWN;
                        flags       <= 4'b0000;
                        cmd_valid_q <= 1'b1;
                        cmd_q       <= CMD_SPAWN;
                    end
                end
                S_SPAWN: begin
                    if (accept) begin
                        flags <= 4'b0000;
                        if (spawn_blocked) begin
                            state     <= S_OVER;
                            game_over <= 1'b1;
                        end else begin
                            state <= S_FALL;
                        end
                    end
                end
                S_FALL, S_LOCK_WAIT: begin
                    if (accept && cmd_q == CMD_DOWN && state == S_LOCK_WAIT) begin
                        state <= S_FALL;
                    end else if (!cmd_valid_q) begin
                        if (flags[F_ROT]) begin
                            cmd_valid_q <= 1'b1;
                            cmd_q       <= CMD_ROTATE;
                        end else if (flags[F_LEFT]) begin
                            cmd_valid_q <= 1'b1;
                            cmd_q       <= CMD_LEFT;
                        end else if (flags[F_RIGHT]) begin
                            cmd_valid_q <= 1'b1;
                            cmd_q       <= CMD_RIGHT;
                        end else if (flags[F_GRAV]) begin
                            // blocked_down is sampled only here; an offered
                            // DOWN stays offered whatever the board does next.
                            if (!blocked_down) begin
                                cmd_valid_q <= 1'b1;
                                cmd_q       <= CMD_DOWN;
                            end else if (state == S_FALL) begin
                                flags    <= {grav_evt, flags_nxt[2:0]};
                                lock_cnt <= 4'(LOCK_TICKS - 1);
                                state    <= S_LOCK_WAIT;
                            end else if (lock_cnt == 4'd0) begin
                                state       <= S_LOCK;
                                flags       <= 4'b0000;
                                cmd_valid_q <= 1'b1;
                                cmd_q       <= CMD_LOCK;
                            end else begin
                                flags    <= {grav_evt, flags_nxt[2:0]};
                                lock_cnt <= lock_cnt - 4'd1;
                            end
                        end
                    end
                end
                S_LOCK: begin
                    if (accept) begin
                        state <= S_CLEAR;
                        flags <= 4'b0000;
                    end
                end
                S_CLEAR: begin
                    if (clear_done) begin
                        state       <= S_SPAWN;
                        flags       <= 4'b0000;
                        cmd_valid_q <= 1'b1;
                        cmd_q       <= CMD_SPAWN;
                    end
                end
                S_OVER: begin
                    flags <= 4'b0000;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tetris_move_scheduler.sv
// Directed bench for tetris_move_scheduler. Inputs change and outputs are
// sampled on the falling clock edge.
module tb_tetris_move_scheduler;

    logic       clk;
    logic       reset;
    logic       start;
    logic       move;
    logic       moveFast;
    logic       soft_drop;
    logic       left;
    logic       right;
    logic       rotate;
    logic       blocked_down;
    logic       spawn_blocked;
    logic       clear_done;
    logic       game_over;
    logic [2:0] state_o;

    int n_checks = 0;
    int n_err    = 0;

    tetris_move_scheduler_if bus ();

    tetris_move_scheduler #(.LOCK_TICKS(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .move         (move),
        .moveFast     (moveFast),
        .soft_drop    (soft_drop),
        .left         (left),
        .right        (right),
        .rotate       (rotate),
        .blocked_down (blocked_down),
        .spawn_blocked(spawn_blocked),
        .clear_done   (clear_done),
        .cmd_bus      (bus),
        .game_over    (game_over),
        .state_o      (state_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Gravity pulse followed by the arbitration edge.
    task automatic do_move();
        move = 1'b1;
        tick();
        move = 1'b0;
        tick();
    endtask

    // Count offered-command cycles over n cycles (cmd_ready assumed 1).
    task automatic count_cmds(input int n, output int cnt, output int last);
        cnt  = 0;
        last = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (bus.cmd_valid) begin
                cnt++;
                last = int'(bus.cmd);
            end
        end
    endtask

    int seq_cmd[4];
    int seq_cyc[4];
    int nseq;
    int cnt;
    int last;

    initial begin
        reset = 1'b0; start = 1'b0; move = 1'b0; moveFast = 1'b0;
        soft_drop = 1'b0; left = 1'b0; right = 1'b0; rotate = 1'b0;
        blocked_down = 1'b0; spawn_blocked = 1'b0; clear_done = 1'b0;
        bus.cmd_ready = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        check("reset_state", int'(state_o), 0);
        check("reset_valid", int'(bus.cmd_valid), 0);
        check("reset_cmd", int'(bus.cmd), 0);
        check("reset_over", int'(game_over), 0);

        // Spawn and first drop
        bus.cmd_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("spawn_valid", int'(bus.cmd_valid), 1);
        check("spawn_cmd", int'(bus.cmd), 6);
        check("spawn_state", int'(state_o), 1);
        tick();
        check("fall_state", int'(state_o), 2);
        check("fall_idle_valid", int'(bus.cmd_valid), 0);
        move = 1'b1;
        tick();
        move = 1'b0;
        check("drop_latency", int'(bus.cmd_valid), 0);
        tick();
        check("drop_valid", int'(bus.cmd_valid), 1);
        check("drop_cmd", int'(bus.cmd), 4);
        tick();
        check("drop_done", int'(bus.cmd_valid), 0);

        // Priority and saturation
        bus.cmd_ready = 1'b0;
        left = 1'b1; right = 1'b1; rotate = 1'b1; move = 1'b1;
        tick();
        right = 1'b0; rotate = 1'b0; move = 1'b0;
        tick();
        left = 1'b0;
        check("prio_first", int'(bus.cmd), 3);
        tick();
        check("prio_hold_valid", int'(bus.cmd_valid), 1);
        check("prio_hold_cmd", int'(bus.cmd), 3);
        bus.cmd_ready = 1'b1;
        nseq = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.cmd_valid && nseq < 4) begin
                seq_cmd[nseq] = int'(bus.cmd);
                seq_cyc[nseq] = i;
                nseq++;
            end else if (bus.cmd_valid) begin
                nseq++;
            end
            tick();
        end
        check("prio_count", nseq, 4);
        check("prio_cmd0", seq_cmd[0], 3);
        check("prio_cmd1", seq_cmd[1], 1);
        check("prio_cmd2", seq_cmd[2], 2);
        check("prio_cmd3", seq_cmd[3], 4);
        check("prio_gap1", seq_cyc[1] - seq_cyc[0], 2);
        check("prio_gap3", seq_cyc[3] - seq_cyc[2], 2);

        // Soft drop
        moveFast = 1'b1;
        tick();
        moveFast = 1'b0;
        count_cmds(4, cnt, last);
        check("fast_no_soft", cnt, 0);
        soft_drop = 1'b1;
        moveFast = 1'b1;
        tick();
        moveFast = 1'b0;
        count_cmds(4, cnt, last);
        check("fast_soft_cnt", cnt, 1);
        check("fast_soft_cmd", last, 4);
        move = 1'b1; moveFast = 1'b1;
        tick();
        move = 1'b0; moveFast = 1'b0;
        count_cmds(5, cnt, last);
        check("fast_merge_cnt", cnt, 1);
        soft_drop = 1'b0;

        // DOWN stays offered after blocked_down rises
        bus.cmd_ready = 1'b0;
        do_move();
        blocked_down = 1'b1;
        tick();
        check("down_held_cmd", int'(bus.cmd), 4);
        check("down_held_state", int'(state_o), 2);
        bus.cmd_ready = 1'b1;
        tick();
        check("down_held_acc", int'(bus.cmd_valid), 0);

        // Lock delay (LOCK_TICKS = 2)
        do_move();
        check("lock1_state", int'(state_o), 3);
        check("lock1_valid", int'(bus.cmd_valid), 0);
        do_move();
        check("lock2_state", int'(state_o), 3);
        check("lock2_valid", int'(bus.cmd_valid), 0);
        do_move();
        check("lock3_state", int'(state_o), 4);
        check("lock3_cmd", int'(bus.cmd), 5);
        tick();
        check("clear_state", int'(state_o), 5);
        tick();
        tick();
        check("clear_wait", int'(state_o), 5);
        clear_done = 1'b1;
        tick();
        clear_done = 1'b0;
        check("respawn_state", int'(state_o), 1);
        check("respawn_cmd", int'(bus.cmd), 6);
        tick();
        check("respawn_fall", int'(state_o), 2);

        // Lock escape, with a lateral move served in LOCK_WAIT
        do_move();
        check("esc_wait", int'(state_o), 3);
        left = 1'b1;
        tick();
        left = 1'b0;
        tick();
        check("esc_left_cmd", int'(bus.cmd), 1);
        check("esc_left_state", int'(state_o), 3);
        tick();
        blocked_down = 1'b0;
        do_move();
        check("esc_down_cmd", int'(bus.cmd), 4);
        tick();
        check("esc_state", int'(state_o), 2);

        // Game over
        blocked_down = 1'b1;
        do_move();
        do_move();
        do_move();
        check("go_lock_cmd", int'(bus.cmd), 5);
        tick();
        spawn_blocked = 1'b1;
        clear_done = 1'b1;
        tick();
        clear_done = 1'b0;
        tick();
        check("go_state", int'(state_o), 6);
        check("go_flag", int'(game_over), 1);
        check("go_valid", int'(bus.cmd_valid), 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("go_start_ignored", int'(state_o), 6);
        check("go_sticky", int'(game_over), 1);

        // Reset, then asynchronous reset with a command outstanding
        reset = 1'b0;
        tick();
        reset = 1'b1;
        spawn_blocked = 1'b0;
        blocked_down = 1'b0;
        tick();
        check("rst_over", int'(game_over), 0);
        check("rst_state", int'(state_o), 0);
        bus.cmd_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("out_valid", int'(bus.cmd_valid), 1);
        #2;
        reset = 1'b0;
        #1;
        check("async_valid", int'(bus.cmd_valid), 0);
        check("async_cmd", int'(bus.cmd), 0);
        check("async_state", int'(state_o), 0);
        tick();
        reset = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
